// File: rtl/sw_debounce_sel.sv
// Switch conditioning ahead of the key mux: 2-flop sync, per-bit debounce, change strobe.
// Define AUTO_SCAN_EN to let a synchronized scan_mode replace sel_out with a stepping index.
module sw_debounce_sel #(
  parameter int DATA_W    = 8,
  parameter int SEL_W     = 2,
  parameter int DB_CYCLES = 16,
  parameter int SCAN_DIV  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [SEL_W-1:0]  sw_sel,
  input  logic              scan_mode,
  output logic [DATA_W-1:0] data_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic              chg
);

  localparam int NB = DATA_W + SEL_W;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    q_q, q_d;
  logic [CW-1:0]    cnt_q [NB];
  logic [CW-1:0]    cnt_d [NB];
  logic [SEL_W-1:0] sel_out_q, sel_out_d;
  logic             chg_q, chg_d;

  // Debounce: a bit is accepted only after DB_CYCLES consecutive mismatching samples.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != q_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          q_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic             scan_s1_q, scan_s2_q, scan_prev_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  // Scan sequencer; select debouncing keeps running underneath it.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (scan_s2_q && !scan_prev_q) begin
      pre_d = '0;
      idx_d = '0;
    end else if (scan_s2_q) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        idx_d = idx_q + SEL_W'(1);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    sel_out_d = scan_s2_q ? idx_d : q_d[NB-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_s1_q   <= 1'b0;
      scan_s2_q   <= 1'b0;
      scan_prev_q <= 1'b0;
      pre_q       <= '0;
      idx_q       <= '0;
    end else begin
      scan_s1_q   <= scan_mode;
      scan_s2_q   <= scan_s1_q;
      scan_prev_q <= scan_s2_q;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
    end
  end
`else
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  always_comb begin
    sel_out_d = q_d[NB-1:DATA_W];
  end
`endif

  // Strobe is computed from next-state so it rises together with the new output value.
  always_comb begin
    chg_d = (q_d[DATA_W-1:0] != q_q[DATA_W-1:0]) || (sel_out_d != sel_out_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      q_q       <= '0;
      sel_out_q <= '0;
      chg_q     <= 1'b0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {sw_sel, sw_data};
      sync2_q   <= sync1_q;
      q_q       <= q_d;
      sel_out_q <= sel_out_d;
      chg_q     <= chg_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_out = q_q[DATA_W-1:0];
  assign sel_out  = sel_out_q;
  assign chg      = chg_q;

endmodule

// File: tb/tb_sw_debounce_sel.sv
// Bench for sw_debounce_sel (DB_CYCLES=4, SCAN_DIV=8): directed table, corner sequences, random vs model.
module tb_sw_debounce_sel;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int DB = 4;
  localparam int SD = 8;
  localparam int NB = DW + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sw_data;
  logic [SW-1:0] sw_sel;
  logic          scan_mode;
  logic [DW-1:0] data_out;
  logic [SW-1:0] sel_out;
  logic          chg;

  int total = 0;
  int bad   = 0;

  sw_debounce_sel #(.DATA_W(DW), .SEL_W(SW), .DB_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sw_sel(sw_sel), .scan_mode(scan_mode),
    .data_out(data_out), .sel_out(sel_out), .chg(chg)
  );

  always #5 clk = ~clk;

  // Reference model: pins reach the debouncer two edges late; a bit flips when the
  // last DB samples since its previous flip (or reset) all disagree with it.
  logic [NB:0]   p1, p2, s;
  logic [NB-1:0] hist[$];
  int            since[NB];
  logic [NB-1:0] mq;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_sel, new_sel;
  logic          m_chg, m_prev;
  int            edge_n, entry_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int  k;
    bit  all_diff;
    if (rst) begin
      p1 = '0; p2 = '0; hist.delete();
      for (int i = 0; i < NB; i++) since[i] = 0;
      mq = '0; m_data = '0; m_sel = '0; m_chg = 1'b0; m_prev = 1'b0;
      edge_n = 0; entry_e = 0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = {scan_mode, sw_sel, sw_data};
      hist.push_back(s[NB-1:0]);
      k = hist.size() - 1;
      for (int i = 0; i < NB; i++) begin
        if (k - since[i] + 1 >= DB) begin
          all_diff = 1'b1;
          for (int j = k - DB + 1; j <= k; j++)
            if (hist[j][i] == mq[i]) all_diff = 1'b0;
          if (all_diff) begin
            mq[i]    = ~mq[i];
            since[i] = k + 1;
          end
        end
      end
      new_sel = mq[NB-1:DW];
`ifdef AUTO_SCAN_EN
      if (s[NB]) begin
        if (!m_prev) entry_e = edge_n;
        new_sel = SW'(((edge_n - entry_e) / SD) % (1 << SW));
      end
      m_prev = s[NB];
`endif
      m_chg  = (mq[DW-1:0] != m_data) || (new_sel != m_sel);
      m_data = mq[DW-1:0];
      m_sel  = new_sel;
      edge_n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_data", 32'(data_out), 32'(m_data));
    check("model_sel",  32'(sel_out),  32'(m_sel));
    check("model_chg",  32'(chg),      32'(m_chg));
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] sl;
    int            hold;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
  } vec_t;

  vec_t vecs[10];
  int   n_hi, n_chg, n_bad;

  initial begin
    vecs[0] = '{8'h3C, 2'd1, 8, 8'h3C, 2'd1};
    vecs[1] = '{8'hC3, 2'd1, 3, 8'h3C, 2'd1};
    vecs[2] = '{8'h3C, 2'd1, 8, 8'h3C, 2'd1};
    vecs[3] = '{8'hFF, 2'd0, 6, 8'hFF, 2'd0};
    vecs[4] = '{8'h00, 2'd3, 5, 8'hFF, 2'd0};
    vecs[5] = '{8'h00, 2'd3, 1, 8'h00, 2'd3};
    vecs[6] = '{8'h5A, 2'd2, 8, 8'h5A, 2'd2};
    vecs[7] = '{8'h5B, 2'd2, 2, 8'h5A, 2'd2};
    vecs[8] = '{8'h5A, 2'd2, 8, 8'h5A, 2'd2};
    vecs[9] = '{8'h81, 2'd1, 7, 8'h81, 2'd1};

    // Reset with all data switches on
    rst = 1'b1; sw_data = 8'hFF; sw_sel = '0; scan_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_chg",  32'(chg),      32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_data", 32'(data_out), 32'h0);
    end
    tick();
    check("post_rst_ff",  32'(data_out), 32'hFF);
    check("post_rst_chg", 32'(chg),      32'h1);
    tick();
    check("post_rst_chg_low", 32'(chg), 32'h0);

    sw_data = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    check("settle_00", 32'(data_out), 32'h0);

    // 3-cycle glitch is rejected
    n_hi = 0; n_chg = 0;
    sw_data = 8'h08;
    for (int i = 0; i < 3; i++) begin tick(); n_chg += int'(chg); end
    sw_data = 8'h00;
    for (int i = 0; i < 10; i++) begin tick(); n_chg += int'(chg); n_hi += int'(data_out == 8'h08); end
    check("glitch3_hi",  32'(n_hi),  32'd0);
    check("glitch3_chg", 32'(n_chg), 32'd0);

    // 4-cycle pulse passes for exactly 4 cycles
    n_hi = 0; n_chg = 0;
    sw_data = 8'h08;
    for (int i = 0; i < 4; i++) begin tick(); n_chg += int'(chg); n_hi += int'(data_out == 8'h08); end
    sw_data = 8'h00;
    for (int i = 0; i < 12; i++) begin tick(); n_chg += int'(chg); n_hi += int'(data_out == 8'h08); end
    check("pulse4_hi",  32'(n_hi),  32'd4);
    check("pulse4_chg", 32'(n_chg), 32'd2);

    // Simultaneous data and select change
    sw_data = 8'hA5; sw_sel = 2'd2;
    for (int i = 0; i < 5; i++) tick();
    check("simul_pre_data", 32'(data_out), 32'h0);
    check("simul_pre_sel",  32'(sel_out),  32'h0);
    tick();
    check("simul_data", 32'(data_out), 32'hA5);
    check("simul_sel",  32'(sel_out),  32'h2);
    check("simul_chg",  32'(chg),      32'h1);
    tick();
    check("simul_chg_low", 32'(chg), 32'h0);

    // Reset in the middle of a debounce count
    sw_data = 8'h00; sw_sel = 2'd0;
    for (int i = 0; i < 8; i++) tick();
    sw_sel = 2'd3;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sel", 32'(sel_out), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_hold", 32'(sel_out), 32'h0);
    end
    tick();
    check("midrst_sel3", 32'(sel_out), 32'h3);

    // Directed table
    sw_data = 8'h3C; sw_sel = 2'd1;
    for (int i = 0; i < 8; i++) tick();
    foreach (vecs[v]) begin
      sw_data = vecs[v].d; sw_sel = vecs[v].sl;
      for (int i = 0; i < vecs[v].hold; i++) tick();
      check($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].ed));
      check($sformatf("vec%0d_sel", v),  32'(sel_out),  32'(vecs[v].es));
    end

    sw_data = 8'h00; sw_sel = 2'd1;
    for (int i = 0; i < 8; i++) tick();
`ifdef AUTO_SCAN_EN
    scan_mode = 1'b1;
    tick(); tick();
    check("scan_entry_pre", 32'(sel_out), 32'h1);
    tick();
    check("scan_entry_sel", 32'(sel_out), 32'h0);
    check("scan_entry_chg", 32'(chg),     32'h1);
    for (int st = 1; st <= 4; st++) begin
      for (int i = 0; i < 7; i++) tick();
      check("scan_hold", 32'(sel_out), 32'(2'(st - 1)));
      tick();
      check("scan_step_sel", 32'(sel_out), 32'(2'(st)));
      check("scan_step_chg", 32'(chg),     32'h1);
    end
    scan_mode = 1'b0;
    tick(); tick();
    check("scan_exit_pre", 32'(sel_out), 32'h0);
    tick();
    check("scan_exit_sel", 32'(sel_out), 32'h1);
    check("scan_exit_chg", 32'(chg),     32'h1);
`else
    n_chg = 0; n_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) scan_mode = ~scan_mode;
      tick();
      n_chg += int'(chg);
      n_bad += int'(sel_out != 2'd1);
    end
    check("noscan_chg", 32'(n_chg), 32'd0);
    check("noscan_sel", 32'(n_bad), 32'd0);
    scan_mode = 1'b0;
`endif

    // Random stimulus against the model
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      case ($urandom_range(0, 2))
        0: sw_data = DW'($urandom);
        1: sw_data = sw_data ^ (DW'(1) << $urandom_range(0, DW - 1));
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) sw_sel = SW'($urandom);
      if ($urandom_range(0, 9) == 0) scan_mode = ~scan_mode;
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sw_debounce_sel.md
Name: sw_debounce_sel

Overview:
- Input-conditioning stage directly upstream of the 4-to-1 2-bit key mux.
- Synchronizes and debounces raw slide-switch inputs (8 data bits, 2 select bits).
- Presents glitch-free data/select buses plus a one-cycle change strobe for the mux and LED/display logic.
- Optionally replaces the select with an auto-scanning sequencer.

Parameters:
- DATA_W, 8, width of the debounced data bus (mux data input).
- SEL_W, 2, width of the debounced select bus (mux key).
- DB_CYCLES, 16, consecutive cycles a synchronized bit must differ from its stable value before it is accepted; legal range >= 2.
- SCAN_DIV, 1024, clock cycles per auto-scan step; legal range >= 2; used only with AUTO_SCAN_EN.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- sw_data  input  DATA_W  raw asynchronous data switches.
- sw_sel  input  SEL_W  raw asynchronous select switches.
- scan_mode  input  1  raw auto-scan request; ignored when AUTO_SCAN_EN is undefined.
- data_out  output  DATA_W  debounced data, to mux data input.
- sel_out  output  SEL_W  debounced or scanned select, to mux key.
- chg  output  1  one-cycle pulse when data_out or sel_out changes value.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst is synchronous, active-high, sampled on the clk rising edge.
  - At reset, all registers clear on that edge: sync flops, per-bit counters, data_out=0, sel_out=0, chg=0, scan prescaler=0, scan state=0.
  - Reset mid-count discards all partial debounce progress.
- Synchronizer:
  - Every raw bit (sw_data, sw_sel, scan_mode) passes through a 2-flop synchronizer.
  - Synchronized value s[i] lags the pin by 2 cycles.
- Per-bit debounce (independent for each of the DATA_W+SEL_W bits):
  - Each bit has a stable register q[i] and a counter cnt[i] of width $clog2(DB_CYCLES).
  - If s[i]==q[i]: cnt[i] <= 0.
  - If s[i]!=q[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If s[i]!=q[i] and cnt[i]==DB_CYCLES-1: q[i] <= s[i] and cnt[i] <= 0.
  - Net effect: a mismatch on s[i] for DB_CYCLES consecutive cycles updates q[i] on the DB_CYCLES-th edge.
  - Pin-to-output latency is 2+DB_CYCLES cycles.
  - Any pulse or glitch shorter than DB_CYCLES cycles (as seen at s[i]) produces no output change; the counter restarts from 0 on each return to the stable value.
  - Counters never wrap.
- Outputs:
  - data_out = q of the data bits.
  - sel_out = q of the select bits (normal mode).
- chg:
  - Registered.
  - High for exactly the first cycle in which a new data_out/sel_out value is visible.
  - Multiple bits changing on the same edge produce a single one-cycle pulse.
  - Changes on back-to-back edges keep chg high for consecutive cycles.
  - Low during reset and in the cycle after reset.
- No handshake: the consumer is purely combinational and samples continuously.

Optional Feature:
- Macro: AUTO_SCAN_EN.
- Defined:
  - The synchronized scan_mode (not debounced) controls a scan sequencer.
  - Rising edge of scan_mode: prescaler and scan index clear to 0, and sel_out = 0 on the next cycle.
  - While scan_mode=1: prescaler counts 0..SCAN_DIV-1; on reaching SCAN_DIV-1 it wraps to 0 and the scan index increments modulo 2^SEL_W (3 wraps to 0).
  - sel_out = scan index; chg pulses on each step and on mode entry if sel_out changed.
  - Falling edge of scan_mode: sel_out returns to the debounced select value on the next cycle.
  - Select-bit debouncing continues in the background during scan.
- Undefined: scan_mode is unused, no sequencer logic exists, and sel_out is always the debounced select.

Test Plan:
- Reset behaviour, DB_CYCLES=4: assert rst with sw_data=8'hFF, release, hold -> data_out stays 0 through reset; becomes 8'hFF on cycle 6 after release (2 sync + 4); chg=1 on that cycle only.
- Glitch rejection, DB_CYCLES=4, stable 8'h00: pulse sw_data[3] high for 3 cycles -> data_out remains 8'h00, chg never asserts; a 4-cycle pulse -> data_out=8'h08 for exactly 4 cycles.
- Simultaneous change: sw_data 8'h00->8'hA5 and sw_sel 0->2 on the same edge -> both outputs update on the same cycle (pin+6); a single one-cycle chg pulse.
- Reset mid-count: sw_sel 0->3, assert rst 3 cycles later for 1 cycle -> sel_out=0; sel_out becomes 3 exactly 6 cycles after rst deasserts.
- Auto-scan, AUTO_SCAN_EN defined, SCAN_DIV=8, sw_sel=1: raise scan_mode -> sel_out=0 at pin+3, then 1,2,3,0 every 8 cycles with chg on each step; drop scan_mode -> sel_out=1 at pin+3.
- AUTO_SCAN_EN undefined: toggle scan_mode freely -> sel_out tracks only the debounced sw_sel; no chg pulses from scan_mode activity.
